// File: rtl/data_bus_fabric.sv
// CPU data-port interconnect: address-sliced slot decode, wait-state handshake, unmapped-slot error.
// Optional hung-access abort is built only when FABRIC_TIMEOUT_EN is defined.
module data_bus_fabric #(
  parameter int SLAVE_CNT = 4,
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int SEL_MSB   = 31,
  parameter int SEL_LSB   = 28,
  parameter int TIMEOUT   = 15
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        m_req,
  input  logic                        m_we,
  input  logic [ADDR_W-1:0]           m_addr,
  input  logic [DATA_W-1:0]           m_wdata,
  input  logic [DATA_W/8-1:0]         m_mask,
  output logic [DATA_W-1:0]           m_rdata,
  output logic                        m_ready,
  output logic                        m_err,
  output logic [SLAVE_CNT-1:0]        s_sel,
  output logic                        s_we,
  output logic [ADDR_W-1:0]           s_addr,
  output logic [DATA_W-1:0]           s_wdata,
  output logic [DATA_W/8-1:0]         s_mask,
  input  logic [SLAVE_CNT*DATA_W-1:0] s_rdata,
  input  logic [SLAVE_CNT-1:0]        s_ready
);

  localparam int IDX_W  = SEL_MSB - SEL_LSB + 1;
  localparam int MASK_W = DATA_W / 8;

  if (TIMEOUT < 1 || SLAVE_CNT < 1 || SLAVE_CNT > 16 || (DATA_W % 8) != 0) begin : g_bad_cfg
    $error("data_bus_fabric: illegal parameter set");
  end

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                          state_q, state_d;
  logic                            swe_q, swe_d;
  logic [ADDR_W-1:0]               addr_q, addr_d;
  logic [DATA_W-1:0]               wdata_q, wdata_d;
  logic [MASK_W-1:0]               mask_q, mask_d;
  logic [IDX_W-1:0]                idx_q, idx_d;
  logic [SLAVE_CNT-1:0]            sel_q, sel_d;
  logic [DATA_W-1:0]               rdata_q, rdata_d;
  logic                            ready_q, ready_d;
  logic                            err_q, err_d;
  logic                            we_q, we_d;

  logic [SLAVE_CNT-1:0][DATA_W-1:0] slot_rdata;
  logic [IDX_W-1:0]                m_idx;
  logic                            mapped;
  logic                            ready_sel;
  logic [DATA_W-1:0]               rdata_sel;

  for (genvar i = 0; i < SLAVE_CNT; i++) begin : g_slot
    assign slot_rdata[i] = s_rdata[i*DATA_W +: DATA_W];
  end

  assign m_idx  = m_addr[SEL_MSB:SEL_LSB];
  assign mapped = (32'(m_idx) < 32'(SLAVE_CNT));

  // Only the latched slot's ready/data matter; the rest are ignored.
  always_comb begin
    ready_sel = 1'b0;
    rdata_sel = '0;
    for (int i = 0; i < SLAVE_CNT; i++) begin
      if (idx_q == IDX_W'(i)) begin
        ready_sel = s_ready[i];
        rdata_sel = slot_rdata[i];
      end
    end
  end

`ifdef FABRIC_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
`endif

  always_comb begin
    state_d = state_q;
    swe_d   = swe_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    mask_d  = mask_q;
    idx_d   = idx_q;
    sel_d   = sel_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    we_d    = we_q;
    ready_d = 1'b0;
`ifdef FABRIC_TIMEOUT_EN
    wcnt_d  = wcnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (m_req && mapped) begin
          state_d = ACCESS;
          we_d    = m_we;
          swe_d   = m_we;
          addr_d  = m_addr;
          wdata_d = m_wdata;
          mask_d  = m_mask;
          idx_d   = m_idx;
          rdata_d = '0;
          err_d   = 1'b0;
          sel_d   = '0;
          for (int i = 0; i < SLAVE_CNT; i++)
            if (m_idx == IDX_W'(i)) sel_d[i] = 1'b1;
`ifdef FABRIC_TIMEOUT_EN
          wcnt_d  = '0;
`endif
        end else if (m_req) begin
          // Unmapped: answer next cycle, slaves never strobed.
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
          rdata_d = '0;
        end
      end
      ACCESS: begin
        if (ready_sel) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b0;
          sel_d   = '0;
          swe_d   = 1'b0;
          if (!we_q) rdata_d = rdata_sel;
        end
`ifdef FABRIC_TIMEOUT_EN
        else if (wcnt_q == CNT_W'(TIMEOUT)) begin
          state_d = RESP;
          ready_d = 1'b1;
          err_d   = 1'b1;
          sel_d   = '0;
          swe_d   = 1'b0;
        end else begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
`endif
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      swe_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mask_q  <= '0;
      idx_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      we_q    <= 1'b0;
`ifdef FABRIC_TIMEOUT_EN
      wcnt_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      swe_q   <= swe_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      mask_q  <= mask_d;
      idx_q   <= idx_d;
      sel_q   <= sel_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      we_q    <= we_d;
`ifdef FABRIC_TIMEOUT_EN
      wcnt_q  <= wcnt_d;
`endif
    end
  end

  assign m_rdata = rdata_q;
  assign m_ready = ready_q;
  assign m_err   = err_q;
  assign s_sel   = sel_q;
  assign s_we    = swe_q;
  assign s_addr  = addr_q;
  assign s_wdata = wdata_q;
  assign s_mask  = mask_q;

endmodule

// File: doc/data_bus_fabric.md
# data_bus_fabric

Parametrised data-bus interconnect between the CPU data port and up to `SLAVE_CNT` memory-mapped peripherals (RAM, GPIO, future timers/UART). It generalises the fixed memory/GPIO address decoder and read multiplexer.
- Adds a registered request/ready handshake, so slaves may insert wait states.
- Flags accesses to unmapped slots with an error response.
- Optionally aborts hung accesses after a bounded timeout.

## Interface
Parameters:
- `SLAVE_CNT`, 4: number of slave slots, 1..16.
- `DATA_W`, 32: data width, multiple of 8.
- `ADDR_W`, 32: address width.
- `SEL_MSB`, 31: high bit of the slot-index field in the address.
- `SEL_LSB`, 28: low bit of the slot-index field.
- `TIMEOUT`, 15: maximum wait cycles in ACCESS before an error response, ≥1.

Ports:
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `m_req` in 1: master request, held until `m_ready`.
- `m_we` in 1: 1 = write, 0 = read.
- `m_addr` in `ADDR_W`: byte address.
- `m_wdata` in `DATA_W`: write data.
- `m_mask` in `DATA_W/8`: byte write mask.
- `m_rdata` out `DATA_W`: read data, valid while `m_ready`.
- `m_ready` out 1: one-cycle completion pulse.
- `m_err` out 1: error qualifier, valid while `m_ready`.
- `s_sel` out `SLAVE_CNT`: one-hot slave select.
- `s_we` out 1: write enable to the selected slave.
- `s_addr` out `ADDR_W`: address to slaves, full address passed through.
- `s_wdata` out `DATA_W`: write data to slaves.
- `s_mask` out `DATA_W/8`: byte mask to slaves.
- `s_rdata` in `SLAVE_CNT*DATA_W`: flattened slave read data, slot i at bits [i*DATA_W +: DATA_W].
- `s_ready` in `SLAVE_CNT`: per-slave completion.

## Operation
- Slot index `idx = m_addr[SEL_MSB:SEL_LSB]`. If `idx >= SLAVE_CNT`, the access is unmapped.
- FSM states: IDLE, ACCESS, RESP.
  - IDLE → ACCESS: `m_req` is 1 and the slot is mapped. Latch `m_we`, `m_addr`, `m_wdata`, `m_mask` and `idx` into request registers; clear the wait counter.
  - IDLE → RESP: `m_req` is 1 and the slot is unmapped. Set the error flag; slaves see no strobe.
  - ACCESS: `s_sel[idx]` is 1 and `s_we` equals the latched `m_we`. When `s_ready[idx]` is 1, capture slot `idx` of `s_rdata` into the read register (reads only) and go to RESP with error 0. Otherwise increment the wait counter. `s_ready` bits of unselected slots are ignored.
  - RESP: `m_ready` is 1 for exactly one cycle. `m_err` is the error flag. `m_rdata` is the captured data, or 0 on error and on writes. Always returns to IDLE.
- Outside ACCESS, `s_sel` is all-zero and `s_we` is 0.
- `s_addr`, `s_wdata` and `s_mask` always drive the latched request registers.
- A `m_req` still high in the IDLE cycle after RESP starts a new transaction. The master must deassert `m_req` in the cycle it sees `m_ready` unless it issues back-to-back accesses.
- Error writes modify no slave.
- Wait counter width is `$clog2(TIMEOUT+1)`. It saturates and never wraps.

## Timing
- Reset, asynchronous and active-low: state IDLE. All outputs 0: `m_rdata`, `m_ready`, `m_err`, `s_sel`, `s_we`, `s_addr`, `s_wdata`, `s_mask`. Wait counter 0.
- Reset mid-ACCESS drops `s_sel` immediately. No response is issued.
- Mapped, zero-wait slave: `m_req` sampled in cycle 0, `s_sel` high in cycle 1, `m_ready` high in cycle 2. Minimum latency is 2 cycles.
- Each wait cycle adds 1 cycle of latency.
- Unmapped access: `m_ready`=1 and `m_err`=1 in cycle 1.
- Minimum issue interval for back-to-back accesses: 3 cycles.

## Configuration
- `FABRIC_TIMEOUT_EN` defined: in ACCESS, if the wait counter equals `TIMEOUT` and the selected slave's `s_ready` is 0, go to RESP with the error flag set. The slave sees `s_sel` for exactly `TIMEOUT+1` cycles. A `s_ready` arriving in the same cycle wins, with no error.
- Undefined: no counter logic is built; ACCESS waits indefinitely for `s_ready[idx]`.

## Test plan
- Reset held low with `m_req`=1 → all outputs 0, `s_sel`=0; after release, first access completes normally.
- Read, slot 1, `m_addr`=0x1000_0004, `s_ready[1]` tied 1, `s_rdata` slot 1 = 0xDEADBEEF → `s_sel`=4'b0010 in cycle 1; `m_ready`=1, `m_rdata`=0xDEADBEEF, `m_err`=0 in cycle 2.
- Write, slot 0, mask 4'b0011, `m_wdata`=0x0000_ABCD, slave asserts `s_ready[0]` after 3 wait cycles → `s_we`=1 and `s_mask`=4'b0011 for 4 cycles; `m_ready` in cycle 5; `m_rdata`=0.
- Access to `m_addr`=0xF000_0000 with `SLAVE_CNT`=4 → `s_sel` never asserted; `m_ready`=1 and `m_err`=1 in cycle 1.
- With `FABRIC_TIMEOUT_EN` and `TIMEOUT`=15, slave never ready → `s_sel` high for 16 cycles; `m_err`=1, `m_ready` in cycle 17. Repeat with `s_ready` in the 16th cycle → `m_err`=0.
- Reset pulse while in ACCESS, slot 2 → `s_sel` drops asynchronously; no `m_ready`; next request is served from IDLE.
